// File: rtl/latch_access_arbiter_pkg.sv
// Shared opcodes and FSM encoding for the latch access arbiter.
package latch_access_arbiter_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/latch_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int j;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/latch_access_arbiter.sv
// Round-robin arbiter that owns one transparent latch and drives its
// setup / strobe / hold sequence on behalf of N requesters.
module latch_access_arbiter #(
    parameter int W           = 4,
    parameter int N           = 4,
    parameter int GATE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   op,
    input  logic [W*N-1:0]   data,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic             busy,
    output logic [W-1:0]     latch_d,
    output logic             latch_gate,
    output logic             latch_aset,
    output logic             latch_aclr
);

    import latch_access_arbiter_pkg::*;

    localparam int IW = $clog2(N);

    if (GATE_CYCLES < 1 || GATE_CYCLES > 255) begin : g_bad_gate
        $error("GATE_CYCLES must be in 1..255");
    end
    if (N < 2 || N > 16) begin : g_bad_n
        $error("N must be in 2..16");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  latch_d_q, latch_d_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  done_q, done_d;
    logic          busy_q, busy_d;
    logic          gate_q, gate_d;
    logic          aset_q, aset_d;
    logic          aclr_q, aclr_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Strobes are registered from the current state, so each output lags
    // the FSM by one cycle and never toggles alongside latch_d.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        op_d      = op_q;
        data_d    = data_q;
        latch_d_d = latch_d_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        gate_d    = 1'b0;
        aset_d    = 1'b0;
        aclr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_SETUP;
                    sel_d   = pick_idx;
                    op_d    = op[2*pick_idx +: 2];
                    data_d  = data[W*pick_idx +: W];
                    gnt_d   = pick_gnt;
                end
            end
            S_SETUP: begin
                latch_d_d = (op_q == OP_LOAD) ? data_q : '0;
                cnt_d     = 8'(GATE_CYCLES - 1);
                state_d   = S_PULSE;
            end
            S_PULSE: begin
                gate_d = (op_q == OP_LOAD);
                aclr_d = (op_q == OP_CLR);
                aset_d = (op_q == OP_SET);
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                done_d  = gnt_q;
                gnt_d   = '0;
                ptr_d   = (sel_q == IW'(N - 1)) ? '0 : sel_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            op_q      <= '0;
            data_q    <= '0;
            latch_d_q <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            gate_q    <= 1'b0;
            aset_q    <= 1'b0;
            aclr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            op_q      <= op_d;
            data_q    <= data_d;
            latch_d_q <= latch_d_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            gate_q    <= gate_d;
            aset_q    <= aset_d;
            aclr_q    <= aclr_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign latch_d    = latch_d_q;
    assign latch_gate = gate_q;
    assign latch_aset = aset_q;
    assign latch_aclr = aclr_q;

endmodule

// File: doc/latch_access_arbiter.md
Name: latch_access_arbiter

Overview:
- Shares one parameterized transparent latch (W-bit data, gate, async set, async clear) among N requesters.
- Arbitrates round-robin and captures the winning request's operation and data.
- Drives a glitch-free, fixed-timing setup / gate pulse / hold sequence onto the latch control pins.
- Sits between requesting blocks and the latch instance; the latch pins are driven only by this block.

Parameters:
- W, 4, latch data width.
- N, 4, number of requesters (2..16).
- GATE_CYCLES, 2, cycles each strobe (gate/aset/aclr) is held high; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request level; held until matching done.
- op  input  2*N  per-requester opcode, requester i at bits [2i+1:2i]:
  - 00 load, 01 clear, 10 set, 11 NOP.
- data  input  W*N  per-requester load value, requester i at [W*i+W-1:W*i].
- gnt  output  N  one-hot grant, high for the whole transaction.
- done  output  N  one-cycle completion pulse to the granted requester.
- busy  output  1  high whenever state is not IDLE.
- latch_d  output  W  data to latch d.
- latch_gate  output  1  latch gate.
- latch_aset  output  1  latch asynchronous set.
- latch_aclr  output  1  latch asynchronous clear.

Behaviour:
- One clock; reset is asynchronous and active-high. All outputs and state are registered.
- Reset values:
  - gnt=0, done=0, busy=0, latch_d=0, latch_gate=0, latch_aset=0, latch_aclr=0.
  - State=IDLE, round-robin pointer=0, pulse counter=0.
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - If req!=0, select the first set bit searching upward from the pointer, wrapping at N-1→0.
  - Capture that requester's op and data into internal registers.
  - Set gnt one-hot and go to SETUP.
  - If req==0, stay in IDLE with all strobes low.
- SETUP (1 cycle):
  - latch_d = captured data for load; all-zeros for clear/set/NOP. All strobes low.
  - Go to PULSE with counter=GATE_CYCLES-1.
- PULSE (GATE_CYCLES cycles):
  - Exactly one strobe high per op: load→latch_gate, clear→latch_aclr, set→latch_aset, NOP→none.
  - latch_d stable. Counter decrements each cycle; go to HOLD when counter==0.
- HOLD (1 cycle):
  - All strobes low, latch_d unchanged (hold time), done[i] high for 1 cycle.
  - Pointer = (i+1) mod N. Next state IDLE; gnt clears on entry to IDLE.
- Latency:
  - req sampled at edge k → gnt visible after edge k.
  - Strobe high from edge k+2 through edge k+1+GATE_CYCLES.
  - done after edge k+2+GATE_CYCLES.
  - Minimum transaction period is GATE_CYCLES+3 cycles.
- Requesters:
  - A requester may drop req or change op/data after gnt; captured values are used.
  - Dropping req mid-transaction does not abort the transaction.
  - A requester must deassert req in the cycle after done, or it is eligible again; it still yields to others by round-robin.
- Invariants:
  - At most one of latch_gate/latch_aset/latch_aclr is high in any cycle.
  - Strobes never go high in the same cycle latch_d changes.
- Reset mid-operation:
  - All strobes drop immediately (asynchronously), gnt/done clear, pointer returns to 0.
  - The interrupted transaction is lost with no done.
- Simultaneous requests are resolved only in IDLE. Requests arriving during a transaction wait.
- Illegal GATE_CYCLES (0 or >255) is caught by an elaboration-time check.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_LOAD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_NOP=2'b11.
  - FSM state encodings: IDLE, SETUP, PULSE, HOLD (2-bit).
- One sub-module, rr_pick:
  - Combinational round-robin selector with inputs req[N] and pointer.
  - Outputs: one-hot grant, encoded index, valid.
- FSM, capture registers and counter stay in latch_access_arbiter.

Test Plan:
- Reset then req=0001, op0=00, data0=4'hA, GATE_CYCLES=2:
  - gnt=0001 after edge 1.
  - latch_d=A with strobes low at edge 2.
  - latch_gate=1 for edges 3–4.
  - done[0] pulse at edge 5.
  - busy low at edge 6.
- req=1111 held for four transactions, all op=00:
  - Grant order 0,1,2,3.
  - Each transaction is 5 cycles apart; each done matches its gnt.
- Opcode mapping:
  - Requester 1 op=01 → only latch_aclr pulses.
  - Requester 2 op=10 → only latch_aset pulses.
  - Requester 3 op=11 → no strobe, but done[3] still pulses.
  - latch_d=0 for all three.
- Change data0 from A to 5 during PULSE:
  - latch_d stays A through HOLD.
- Assert rst for 1 cycle during PULSE with latch_gate=1:
  - All outputs 0 immediately, no done, state IDLE.
  - Next req=0100 → requester 2 granted after 1 edge, pointer restarted at 0.
- Continuous scoreboard check on every cycle:
  - At most one strobe high.
  - latch_d never changes while any strobe is high.
